// File: rtl/instr_realign_buf.sv
// instr_realign_buf: halfword FIFO that realigns fetch words into 16/32-bit instructions,
// dropping the leading halfwords of the first word after a misaligned redirect.
module instr_realign_buf #(
    parameter int          FETCH_HW = 2,
    parameter int          DEPTH_HW = 8,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_fetch_valid,
    input  logic [16*FETCH_HW-1:0]      i_fetch_data,
    output logic                        o_fetch_ready,
    input  logic                        i_flush,
    input  logic [63:0]                 i_flush_target,
    output logic                        o_instr_valid,
    output logic [31:0]                 o_instr,
    output logic [63:0]                 o_instr_pc,
    output logic                        o_is_compr,
    input  logic                        i_instr_ready,
    output logic [$clog2(DEPTH_HW):0]   o_count
);
    localparam int AW = $clog2(DEPTH_HW);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(FETCH_HW);

    typedef enum logic {RUN, REALIGN} state_t;

    state_t        r_state, w_state_next;
    logic [15:0]   r_mem [DEPTH_HW];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count, w_push;
    logic [63:0]   r_pc;
    logic [DW-1:0] r_drop, w_drop_eff;
    logic [15:0]   w_hw0, w_hw1;
    logic [1:0]    w_pop;
    logic          w_compr, w_enough, w_fetch_ready, w_accept;

    assign w_hw0         = r_mem[r_rptr];
    assign w_hw1         = r_mem[r_rptr + AW'(1)];
    assign w_compr       = w_hw0[1:0] != 2'b11;
    assign w_enough      = w_compr ? (r_count != '0) : (r_count >= CW'(2));
    assign w_fetch_ready = r_count <= CW'(DEPTH_HW - FETCH_HW);
    assign w_accept      = i_fetch_valid && w_fetch_ready && !i_flush;
    // Leading halfwords are skipped only for the first word after a redirect.
    assign w_drop_eff    = (r_state == REALIGN) ? r_drop : '0;
    assign w_push        = w_accept ? CW'(FETCH_HW) - CW'(w_drop_eff) : '0;
    assign w_pop         = !(o_instr_valid && i_instr_ready) ? 2'd0 : w_compr ? 2'd1 : 2'd2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= RUN;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = i_flush ? REALIGN : (r_state == REALIGN && w_accept) ? RUN : r_state;
    end

    always_comb begin
        o_fetch_ready = w_fetch_ready;
        o_instr_valid = w_enough && !i_flush;
        o_is_compr    = !o_instr_valid || w_compr;
        o_instr       = !o_instr_valid ? 32'h0000_0001 : w_compr ? {16'h0, w_hw0} : {w_hw1, w_hw0};
        o_instr_pc    = r_pc;
        o_count       = r_count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_pc    <= RESET_PC;
            r_drop  <= '0;
        end else if (i_flush) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_pc    <= i_flush_target;
            r_drop  <= i_flush_target[DW:1];
        end else begin
            r_count <= r_count + w_push - CW'(w_pop);
            r_wptr  <= r_wptr + AW'(w_push);
            r_rptr  <= r_rptr + AW'(w_pop);
            r_pc    <= r_pc + {61'h0, w_pop, 1'b0};
        end
    end

    // Contents need no reset: count gates every read.
    always_ff @(posedge clk) begin
        for (int k = 0; k < FETCH_HW; k++)
            if (w_accept && DW'(k) >= w_drop_eff)
                r_mem[r_wptr + AW'(k) - AW'(w_drop_eff)] <= i_fetch_data[16*k +: 16];
    end
endmodule

// File: tb/tb_instr_realign_buf.sv
// tb_instr_realign_buf: directed and random checks of the realign buffer against a
// halfword-queue reference model (FETCH_HW=2), plus directed FETCH_HW=4 checks.
module tb_instr_realign_buf;
    localparam logic [63:0] RPC_A = 64'h100;
    localparam logic [63:0] RPC_B = 64'h200;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        a_fv = 0, a_fl = 0, a_rdy = 0;
    logic [31:0] a_fd = 0;
    logic [63:0] a_ft = 0;
    logic        a_fr, a_iv, a_ic;
    logic [31:0] a_instr;
    logic [63:0] a_pc;
    logic [3:0]  a_cnt;

    logic        b_fv = 0, b_fl = 0, b_rdy = 0;
    logic [63:0] b_fd = 0;
    logic [63:0] b_ft = 0;
    logic        b_fr, b_iv, b_ic;
    logic [31:0] b_instr;
    logic [63:0] b_pc;
    logic [3:0]  b_cnt;

    instr_realign_buf #(.FETCH_HW(2), .DEPTH_HW(8), .RESET_PC(RPC_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_fetch_valid(a_fv), .i_fetch_data(a_fd),
        .o_fetch_ready(a_fr), .i_flush(a_fl), .i_flush_target(a_ft),
        .o_instr_valid(a_iv), .o_instr(a_instr), .o_instr_pc(a_pc), .o_is_compr(a_ic),
        .i_instr_ready(a_rdy), .o_count(a_cnt));

    instr_realign_buf #(.FETCH_HW(4), .DEPTH_HW(8), .RESET_PC(RPC_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_fetch_valid(b_fv), .i_fetch_data(b_fd),
        .o_fetch_ready(b_fr), .i_flush(b_fl), .i_flush_target(b_ft),
        .o_instr_valid(b_iv), .o_instr(b_instr), .o_instr_pc(b_pc), .o_is_compr(b_ic),
        .i_instr_ready(b_rdy), .o_count(b_cnt));

    logic [15:0] q[$];
    logic [63:0] m_pc;
    bit          m_realign;
    int          m_drop;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc = RPC_A;
        m_realign = 0;
        m_drop = 0;
    endtask

    task automatic model_check();
        int n;
        bit c, v;
        logic [31:0] ei;
        n = q.size();
        c = n > 0 && q[0][1:0] != 2'b11;
        v = !a_fl && n > 0 && (c || n >= 2);
        ei = !v ? 32'h1 : c ? {16'h0, q[0]} : {q[1], q[0]};
        chk("valid", a_iv, v);
        chk("instr", a_instr, ei);
        chk("compr", a_ic, !v || c);
        chk("pc", a_pc, m_pc);
        chk("count", a_cnt, n);
        chk("fetch_ready", a_fr, n <= 6);
    endtask

    task automatic model_update();
        int n;
        bit c, v, acc;
        if (a_fl) begin
            q.delete();
            m_pc = a_ft;
            m_realign = 1;
            m_drop = int'(a_ft[1]);
        end else begin
            n = q.size();
            acc = a_fv && n <= 6;
            c = n > 0 && q[0][1:0] != 2'b11;
            v = n > 0 && (c || n >= 2);
            if (v && a_rdy) begin
                void'(q.pop_front());
                if (!c) void'(q.pop_front());
                m_pc = m_pc + (c ? 64'd2 : 64'd4);
            end
            if (acc) begin
                for (int k = (m_realign ? m_drop : 0); k < 2; k++) q.push_back(a_fd[16*k +: 16]);
                m_realign = 0;
            end
        end
    endtask

    task automatic cycle();
        #1;
        model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_a(input logic fv, input logic [31:0] fd, input logic fl,
                         input logic [63:0] ft, input logic rdy);
        a_fv = fv; a_fd = fd; a_fl = fl; a_ft = ft; a_rdy = rdy;
    endtask

    task automatic exp_a(input logic v, input logic [31:0] ins, input logic [63:0] pc);
        #1;
        chk("dir_valid", a_iv, v);
        chk("dir_instr", a_instr, ins);
        chk("dir_pc", a_pc, pc);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_valid", a_iv, 0);
        chk("rst_instr", a_instr, 32'h1);
        chk("rst_compr", a_ic, 1);
        chk("rst_pc", a_pc, RPC_A);
        chk("rst_count", a_cnt, 0);
        chk("rst_fready", a_fr, 1);
        chk("rst_b_pc", b_pc, RPC_B);
        chk("rst_b_count", b_cnt, 0);
        chk("rst_b_instr", b_instr, 32'h1);
    endtask

    initial begin
        #2 rst_n = 0;
        #1 chk_reset_outputs();
        model_reset();
        @(negedge clk);
        chk_reset_outputs();
        rst_n = 1;
        cycle();

        // Aligned redirect, two compressed instructions in one word
        set_a(0, 0, 1, 64'h1000, 1); cycle();
        set_a(1, 32'h4501_4581, 0, 0, 1); cycle();
        set_a(0, 0, 0, 0, 1); exp_a(1, 32'h4581, 64'h1000); cycle();
        exp_a(1, 32'h4501, 64'h1002); cycle();
        exp_a(0, 32'h1, 64'h1004); cycle();

        // 32-bit instruction straddling two fetch words
        set_a(0, 0, 1, 64'h1000, 1); cycle();
        set_a(1, 32'h0013_4581, 0, 0, 1); cycle();
        set_a(0, 0, 0, 0, 1); exp_a(1, 32'h4581, 64'h1000); cycle();
        exp_a(0, 32'h1, 64'h1002); cycle();
        set_a(1, 32'h4581_0000, 0, 0, 1); exp_a(0, 32'h1, 64'h1002); cycle();
        set_a(0, 0, 0, 0, 1); exp_a(1, 32'h0000_0013, 64'h1002); cycle();
        exp_a(1, 32'h4581, 64'h1006); cycle();
        exp_a(0, 32'h1, 64'h1008); cycle();

        // Misaligned redirect drops the leading halfword
        set_a(0, 0, 1, 64'h2002, 1); cycle();
        set_a(1, 32'h0013_ABCD, 0, 0, 1); cycle();
        set_a(0, 0, 0, 0, 1); exp_a(0, 32'h1, 64'h2002); chk("realign_count", a_cnt, 1); cycle();
        set_a(1, 32'h4581_0000, 0, 0, 1); cycle();
        set_a(0, 0, 0, 0, 1); exp_a(1, 32'h0000_0013, 64'h2002); cycle();
        exp_a(1, 32'h4581, 64'h2006); cycle();

        // Backpressure fills the buffer
        set_a(0, 0, 1, 64'h3000, 0); cycle();
        for (int i = 0; i < 4; i++) begin
            set_a(1, 32'h4581_4581, 0, 0, 0); cycle();
            chk("bp_count", a_cnt, 2 * (i + 1));
        end
        chk("bp_fready_full", a_fr, 0);
        set_a(1, 32'h4581_4581, 0, 0, 1); cycle();
        chk("bp_count_7", a_cnt, 7);
        chk("bp_fready_7", a_fr, 0);

        // Flush wins over simultaneous fetch and pop at count 5
        set_a(0, 0, 0, 0, 1); cycle(); cycle();
        chk("pre_flush_count", a_cnt, 5);
        set_a(1, 32'h4581_4581, 1, 64'h4000, 1); exp_a(0, 32'h1, 64'h3006); cycle();
        set_a(0, 0, 0, 0, 1); #1;
        chk("post_flush_count", a_cnt, 0);
        chk("post_flush_pc", a_pc, 64'h4000);
        chk("post_flush_fready", a_fr, 1);
        cycle();

        // Head PC wraps modulo 2^64
        set_a(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1); cycle();
        set_a(1, 32'h4581_1234, 0, 0, 1); cycle();
        set_a(1, 32'h4501_4502, 0, 0, 1); exp_a(1, 32'h4581, 64'hFFFF_FFFF_FFFF_FFFE); cycle();
        set_a(0, 0, 0, 0, 1); exp_a(1, 32'h4502, 64'h0); cycle();
        exp_a(1, 32'h4501, 64'h2); cycle();

        // Asynchronous reset mid-stream at count 6
        set_a(0, 0, 1, 64'h5000, 0); cycle();
        for (int i = 0; i < 3; i++) begin
            set_a(1, 32'h4581_4581, 0, 0, 0); cycle();
        end
        chk("pre_reset_count", a_cnt, 6);
        set_a(0, 0, 0, 0, 1);
        #2 rst_n = 0;
        #1 chk_reset_outputs();
        model_reset();
        @(negedge clk);
        rst_n = 1;

        // FETCH_HW=4: four compressed instructions from one word
        b_fv = 1; b_fd = 64'h4581_4581_4581_4581; b_rdy = 1; cycle();
        b_fv = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("b_valid", b_iv, 1);
            chk("b_instr", b_instr, 32'h4581);
            chk("b_pc", b_pc, RPC_B + 64'(2 * i));
            chk("b_compr", b_ic, 1);
            cycle();
        end
        #1 chk("b_empty_valid", b_iv, 0);
        chk("b_empty_count", b_cnt, 0);
        b_fl = 1; b_ft = 64'h5006; cycle();
        b_fl = 0; b_fv = 1; b_fd = 64'h4581_0001_0001_0001; cycle();
        b_fv = 0; #1;
        chk("b_drop3_count", b_cnt, 1);
        chk("b_drop3_instr", b_instr, 32'h4581);
        chk("b_drop3_pc", b_pc, 64'h5006);
        cycle();

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            set_a(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 15) == 0,
                  {$urandom, $urandom} & ~64'h1, $urandom_range(0, 3) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
